// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one adder among NREQ requesters with round-robin arbitration.
//   Each operation goes through four steps. The arbiter accepts one operand
//   pair, issues it to the adder, and waits for the result. It then returns
//   sum and carry to the requester that owns the operation. A watchdog
//   aborts an operation whose result never arrives, so a hung adder cannot
//   deadlock the requesters.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (ready is one-hot or zero)
//   req_a/req_b            packed operands, requester i at [i*DWIDTH +: DWIDTH]
//   rsp_valid              one-cycle pulse on the owner's bit
//   rsp_sum/carry/err      shared response payload, held until the next response
//   add_in1/in2/ivalid     to the adder
//   add_sum/carry/ovalid   from the adder
//   add_busy               adder cannot take a new operation
//   grant_id               owner of the current/last accepted operation
module adder_arbiter #(
  parameter int DWIDTH  = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DWIDTH-1:0]    req_a,
  input  logic [NREQ*DWIDTH-1:0]    req_b,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [DWIDTH-1:0]         rsp_sum,
  output logic                      rsp_carry,
  output logic                      rsp_err,
  output logic [DWIDTH-1:0]         add_in1,
  output logic [DWIDTH-1:0]         add_in2,
  output logic                      add_ivalid,
  input  logic [DWIDTH-1:0]         add_sum,
  input  logic                      add_carry,
  input  logic                      add_ovalid,
  input  logic                      add_busy,
  output logic [$clog2(NREQ)-1:0]   grant_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMAX     = TW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [DWIDTH-1:0] op_a_q, op_a_d;
  logic [DWIDTH-1:0] op_b_q, op_b_d;
  logic              ivalid_q, ivalid_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              err_q, err_d;

  logic              win_found;
  logic [IDW-1:0]    win_idx;
  logic              accept;
  logic [DWIDTH-1:0] sel_a, sel_b;

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Round-robin: first valid requester after last_q, wrapping modulo NREQ.
  // Plain modulo keeps non-power-of-two NREQ correct.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k) % NREQ;
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  // The rstn term keeps ready low while reset is held; the FSM already
  // sits in IDLE then, so otherwise ready would follow req_valid.
  assign accept    = rstn && (state_q == S_IDLE) && !add_busy && win_found;
  assign req_ready = accept ? onehot(win_idx) : '0;
  assign sel_a     = req_a[win_idx*DWIDTH +: DWIDTH];
  assign sel_b     = req_b[win_idx*DWIDTH +: DWIDTH];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    ivalid_d    = 1'b0;
    timer_d     = timer_q;
    rsp_valid_d = '0;
    sum_d       = sum_q;
    carry_d     = carry_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          owner_d  = win_idx;
          grant_d  = win_idx;
          ivalid_d = 1'b1;   // high for the whole ISSUE cycle
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // ovalid is tested first so a result on the last allowed cycle wins
        if (add_ovalid) begin
          sum_d       = add_sum;
          carry_d     = add_carry;
          err_d       = 1'b0;
          rsp_valid_d = onehot(owner_q);
          state_d     = S_RESP;
        end else if (timer_q == TMAX) begin
          sum_d       = '0;
          carry_d     = 1'b0;
          err_d       = 1'b1;
          rsp_valid_d = onehot(owner_q);
          state_d     = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      last_q      <= LAST_RST;
      owner_q     <= '0;
      grant_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      ivalid_q    <= 1'b0;
      timer_q     <= '0;
      rsp_valid_q <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      ivalid_q    <= ivalid_d;
      timer_q     <= timer_d;
      rsp_valid_q <= rsp_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
    end
  end

  assign add_in1    = op_a_q;
  assign add_in2    = op_b_q;
  assign add_ivalid = ivalid_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_sum    = sum_q;
  assign rsp_carry  = carry_q;
  assign rsp_err    = err_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rstn;
  logic [NR-1:0]    req_valid, req_ready, rsp_valid;
  logic [NR*DW-1:0] req_a, req_b;
  logic [DW-1:0]    rsp_sum, add_in1, add_in2, add_sum;
  logic             rsp_carry, rsp_err, add_ivalid, add_carry, add_ovalid, add_busy;
  logic [1:0]       grant_id;

  always #5 clk = ~clk;

  adder_arbiter #(.DWIDTH(DW), .NREQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .add_in1(add_in1), .add_in2(add_in2), .add_ivalid(add_ivalid),
    .add_sum(add_sum), .add_carry(add_carry), .add_ovalid(add_ovalid), .add_busy(add_busy),
    .grant_id(grant_id)
  );

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    logic [7:0] sum;
    logic       carry;
    logic       err;
  } vec_t;

  typedef struct {
    int          id;
    logic [DW-1:0] sum;
    logic        carry;
    logic        err;
  } rsp_t;

  int n_vec = 0, n_err = 0, cyc = 0;

  // requester / environment state (applied to the DUT only inside step)
  logic [DW-1:0] tb_a [NR];
  logic [DW-1:0] tb_b [NR];
  logic [NR-1:0] tb_valid, tb_hold, took;
  logic          tb_busy, tb_rstn;
  int            lat_cfg;
  bit            lat_rand;
  int            pend;
  logic [DW:0]   pres;

  // transaction-level reference model
  bit          sb_on;
  int          m_last, m_owner, m_acc_cyc, m_rsp_cyc, m_free;
  logic [DW-1:0] m_a, m_b;
  logic [DW:0] m_exp;
  bit          m_err;

  int   acc_q[$];
  rsp_t rsp_q[$];
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    oh    = '0;
    oh[i] = 1'b1;
  endfunction

  task automatic sb_reset();
    m_last = NR - 1; m_owner = 0; m_acc_cyc = -10; m_rsp_cyc = -10; m_free = 0; pend = 0;
  endtask

  // Expected behaviour: after an accept at T the arbiter is busy until the
  // response cycle T+2+min(L,TIMEOUT); the next accept goes to the first
  // valid requester after the last owner.
  task automatic sb_check();
    logic [NR-1:0] exp_rdy, exp_rsp;
    int w;
    exp_rdy = '0;
    w = -1;
    if (cyc >= m_free && !tb_busy) begin
      for (int k = 1; k <= NR; k++) begin
        if (w < 0 && tb_valid[(m_last + k) % NR]) w = (m_last + k) % NR;
      end
    end
    if (w >= 0) exp_rdy = oh(w);
    check("req_ready", req_ready, exp_rdy);
    if (w >= 0) begin
      m_owner = w; m_a = tb_a[w]; m_b = tb_b[w];
      m_exp = {1'b0, m_a} + {1'b0, m_b};
      m_acc_cyc = cyc; m_free = 1 << 30;
    end
    check("add_ivalid", add_ivalid, cyc == m_acc_cyc + 1);
    if (cyc == m_acc_cyc + 1) check("grant_id", grant_id, m_owner);
    exp_rsp = (cyc == m_rsp_cyc) ? oh(m_owner) : '0;
    check("rsp_valid", rsp_valid, exp_rsp);
    if (cyc == m_rsp_cyc) begin
      check("rsp_sum",   rsp_sum,   m_err ? '0 : m_exp[DW-1:0]);
      check("rsp_carry", rsp_carry, m_err ? 1'b0 : m_exp[DW]);
      check("rsp_err",   rsp_err,   m_err);
      m_last = m_owner;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    rstn = tb_rstn;
    // adder model: result L cycles after the ivalid cycle
    add_ovalid = 1'b0;
    if (!tb_rstn) pend = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        add_ovalid = 1'b1; add_sum = pres[DW-1:0]; add_carry = pres[DW];
      end
    end
    if (add_ivalid) begin
      int l;
      if (lat_rand) l = ($urandom_range(0, 15) == 0) ? TO + 1 : int'($urandom_range(1, 8));
      else          l = lat_cfg;
      pend = l;
      pres = {1'b0, add_in1} + {1'b0, add_in2};
      if (sb_on) begin
        check("add_in1", add_in1, m_a);
        check("add_in2", add_in2, m_b);
        m_rsp_cyc = cyc + 1 + ((l < TO) ? l : TO);
        m_err     = (l > TO);
        m_free    = m_rsp_cyc + 1;
      end
    end
    // requesters: drop (or renew, if holding) after being accepted
    for (int i = 0; i < NR; i++) begin
      if (took[i]) begin
        took[i] = 1'b0;
        if (tb_hold[i]) begin tb_a[i] = DW'($urandom); tb_b[i] = DW'($urandom); end
        else tb_valid[i] = 1'b0;
      end
      req_a[i*DW +: DW] = tb_a[i];
      req_b[i*DW +: DW] = tb_b[i];
    end
    req_valid = tb_valid;
    add_busy  = tb_busy;
    #3;
    if (sb_on) sb_check();
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) begin took[i] = 1'b1; acc_q.push_back(i); end
      if (rsp_valid[i]) begin
        rsp_t r;
        r.id = i; r.sum = rsp_sum; r.carry = rsp_carry; r.err = rsp_err;
        rsp_q.push_back(r);
      end
    end
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic run_until(input int n, input int bound, input string tag);
    int t;
    t = 0;
    while (rsp_q.size() < n && t < bound) begin step(); t++; end
    check(tag, rsp_q.size() >= n, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_ctl"}, {req_ready, rsp_valid, rsp_carry, rsp_err, add_ivalid, grant_id}, '0);
    check({tag, "_data"}, {rsp_sum, add_in1, add_in2}, '0);
  endtask

  initial begin
    int fair_exp[6];
    fair_exp = '{1, 3, 1, 3, 1, 3};
    tbl[0] = '{0, 8'h7F, 8'h81, 1,      8'h00, 1'b1, 1'b0};
    tbl[1] = '{1, 8'hFF, 8'hFF, 3,      8'hFE, 1'b1, 1'b0};
    tbl[2] = '{2, 8'h12, 8'h34, 2,      8'h46, 1'b0, 1'b0};
    tbl[3] = '{3, 8'h00, 8'h00, 5,      8'h00, 1'b0, 1'b0};
    tbl[4] = '{2, 8'hA5, 8'h5A, TO,     8'hFF, 1'b0, 1'b0};  // ovalid on last WAIT cycle
    tbl[5] = '{1, 8'h80, 8'h80, TO + 1, 8'h00, 1'b0, 1'b1};  // one cycle too late
    tbl[6] = '{0, 8'h01, 8'h01, TO + 5, 8'h00, 1'b0, 1'b1};  // stray ovalid later in IDLE
    tbl[7] = '{3, 8'hC8, 8'h64, 4,      8'h2C, 1'b1, 1'b0};

    tb_rstn = 1'b0; rstn = 1'b0;
    tb_valid = '0; tb_hold = '0; took = '0; tb_busy = 1'b0;
    lat_cfg = 2; lat_rand = 1'b0; sb_on = 1'b0; pend = 0;
    req_valid = '0; req_a = '0; req_b = '0;
    add_sum = '0; add_carry = 1'b0; add_ovalid = 1'b0; add_busy = 1'b0;
    for (int i = 0; i < NR; i++) begin tb_a[i] = '0; tb_b[i] = '0; end
    sb_reset();

    repeat (3) begin step(); chk_zero("reset"); end
    tb_rstn = 1'b1; sb_reset(); sb_on = 1'b1;

    // contention right after reset: order 0,1,2,3
    for (int i = 0; i < NR; i++) begin tb_a[i] = DW'(i); tb_b[i] = 8'h10; end
    tb_valid = '1; acc_q.delete(); rsp_q.delete();
    run_until(4, 80, "cont_done");
    for (int i = 0; i < 4; i++) begin
      if (acc_q.size() > i) check("cont_grant", acc_q[i], i);
      if (rsp_q.size() > i) begin
        check("cont_owner", rsp_q[i].id, i);
        check("cont_sum", rsp_q[i].sum, 8'h10 + i);
      end
    end

    // fairness: 1 and 3 requesting continuously
    acc_q.delete();
    tb_hold[1] = 1'b1; tb_hold[3] = 1'b1; tb_valid[1] = 1'b1; tb_valid[3] = 1'b1;
    begin
      int t;
      t = 0;
      while (acc_q.size() < 6 && t < 100) begin step(); t++; end
    end
    tb_hold = '0;
    check("fair_count", acc_q.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++) if (acc_q.size() > i) check("fair_grant", acc_q[i], fair_exp[i]);
    drain(40);

    // table of single operations
    foreach (tbl[v]) begin
      rsp_q.delete();
      lat_cfg = tbl[v].lat;
      tb_a[tbl[v].id] = tbl[v].a; tb_b[tbl[v].id] = tbl[v].b; tb_valid[tbl[v].id] = 1'b1;
      run_until(1, TO + 30, "vec_done");
      if (rsp_q.size() > 0) begin
        check("vec_owner", rsp_q[0].id, tbl[v].id);
        check("vec_sum",   rsp_q[0].sum, tbl[v].sum);
        check("vec_carry", rsp_q[0].carry, tbl[v].carry);
        check("vec_err",   rsp_q[0].err, tbl[v].err);
      end
      drain(12);
    end
    check("stray_no_rsp", rsp_q.size(), 1);

    // busy gating
    lat_cfg = 2; tb_busy = 1'b1;
    tb_a[2] = 8'h33; tb_b[2] = 8'h44; tb_valid[2] = 1'b1;
    repeat (20) begin step(); check("busy_ready", req_ready, '0); end
    tb_busy = 1'b0;
    step();
    check("busy_release", req_ready, 4'b0100);
    drain(12);

    // randomized traffic against the model
    lat_rand = 1'b1;
    repeat (400) begin
      for (int i = 0; i < NR; i++) begin
        if (!tb_valid[i] && $urandom_range(0, 3) == 0) begin
          tb_valid[i] = 1'b1; tb_a[i] = DW'($urandom); tb_b[i] = DW'($urandom);
        end
      end
      tb_busy = ($urandom_range(0, 7) == 0);
      step();
    end
    tb_busy = 1'b0;
    drain(300);
    lat_rand = 1'b0;

    // reset while waiting on the adder
    lat_cfg = 30; acc_q.delete();
    tb_a[1] = 8'h21; tb_b[1] = 8'h12; tb_valid[1] = 1'b1;
    begin
      int t;
      t = 0;
      while (acc_q.size() == 0 && t < 20) begin step(); t++; end
    end
    check("rst_pre_accept", acc_q.size(), 1);
    drain(4);
    #2;
    sb_on = 1'b0; tb_rstn = 1'b0; rstn = 1'b0;
    #1;
    chk_zero("rst_async");
    for (int i = 0; i < NR; i++) begin tb_a[i] = DW'(8'h40 + i); tb_b[i] = DW'(i); end
    tb_valid = '1;
    repeat (3) begin step(); chk_zero("rst_hold"); end
    sb_reset(); sb_on = 1'b1; tb_rstn = 1'b1; lat_cfg = 2;
    acc_q.delete(); rsp_q.delete();
    step();
    check("rst_first_grant", req_ready, 4'b0001);
    drain(40);
    check("rst_rsp_count", rsp_q.size(), 4);
    if (rsp_q.size() > 0) check("rst_first_owner", rsp_q[0].id, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
